// File: rtl/router_pkg.sv
// Constants shared by the 1x3 router blocks (FSM, synchronizer, register, FIFO).
package router_pkg;

  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;

  // Header byte layout: {payload_len, dest_addr}
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

endpackage : router_pkg

// File: rtl/router_fifo.sv
// Per-destination packet FIFO of the 1x3 router. Each entry carries a header tag
// bit alongside the byte; a packet-length counter on the read side flags the
// trailing parity byte via pkt_last.
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W,
  parameter int DEPTH  = ROUTER_FIFO_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_last,
  output logic              full,
  output logic              empty,
  output logic              wr_drop
);

  localparam int PTR_W = ADDR_W + 1;
  // Counter holds payload_len + 1 (header length field plus parity byte).
  localparam int LEN_W = DATA_W - HDR_LEN_LSB;
  localparam int CNT_W = LEN_W + 1;

  logic [DATA_W:0]   mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              flush;
  logic              do_wr;
  logic              vld_p0;
  logic [DATA_W:0]   rd_entry_p0;

  // Number of bytes still to come after a header: payload bytes plus parity.
  function automatic logic [CNT_W-1:0] hdr_count(input logic [DATA_W-1:0] hdr);
    logic [LEN_W-1:0] len;
    len = hdr[DATA_W-1:HDR_LEN_LSB];
    return {1'b0, len} + CNT_W'(1);
  endfunction

  // Status flags come straight from the pre-edge pointers.
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign flush       = reset || soft_reset;
  assign do_wr       = write_enb && !full;
  assign vld_p0      = read_enb && !empty;
  assign rd_entry_p0 = mem[rd_ptr[ADDR_W-1:0]];

  // Storage write; contents survive reset and flush, only the pointers move.
  always_ff @(posedge clock) begin
    if (do_wr && !flush) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
    end
  end

  // ---- stage boundary: asynchronous array read -> registered data_out ----
  // Pointers, read register, packet counter and drop flag.
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      pkt_last <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= write_enb && full;
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (vld_p0) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= rd_entry_p0[DATA_W-1:0];
        if (rd_entry_p0[DATA_W]) begin
          // A header always reloads; an unfinished previous packet is truncated.
          count    <= hdr_count(rd_entry_p0[DATA_W-1:0]);
          pkt_last <= 1'b0;
        end else if (count != '0) begin
          count    <= count - CNT_W'(1);
          pkt_last <= (count == CNT_W'(1));
        end else begin
          // Orphan byte outside any packet: pass data, no framing.
          pkt_last <= 1'b0;
        end
      end else begin
        pkt_last <= 1'b0;
      end
    end
  end

endmodule : router_fifo

// File: tb/tb_router_fifo.sv
// Bench for router_fifo: directed scenarios plus a randomized run checked
// against a queue-based packet model.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       pkt_last;
  logic       full;
  logic       empty;
  logic       wr_drop;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [8:0] q[$];
  int         m_count;
  logic [7:0] m_dout;
  logic       m_last;
  logic       m_drop;

  router_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .pkt_last   (pkt_last),
    .full       (full),
    .empty      (empty),
    .wr_drop    (wr_drop)
  );

  always #5 clock = ~clock;

  // Apply one cycle of inputs, advance the model, settle 1ns past the edge.
  task automatic cyc(input logic we, input logic lfd, input logic [7:0] din,
                     input logic re, input logic sr, input logic rs);
    logic [8:0] e;
    bit m_full, m_empty;
    write_enb = we; lfd_state = lfd; data_in = din;
    read_enb = re; soft_reset = sr; reset = rs;
    if (rs || sr) begin
      q.delete(); m_count = 0; m_dout = 8'h00; m_last = 1'b0; m_drop = 1'b0;
    end else begin
      m_full  = (q.size() == 16);
      m_empty = (q.size() == 0);
      m_drop  = we && m_full;
      if (re && !m_empty) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) begin
          m_count = int'(e[7:2]) + 1; m_last = 1'b0;
        end else if (m_count > 0) begin
          m_last = (m_count == 1); m_count--;
        end else begin
          m_last = 1'b0;
        end
      end else begin
        m_last = 1'b0;
      end
      if (we && !m_full) q.push_back({lfd, din});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic lfd, input logic [7:0] d);
    cyc(1'b1, lfd, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1);
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
    n_total++; if (data_out !== 8'h00) $display("FAIL reset_dout: got %h want 00", data_out); else n_pass++;
    n_total++; if (pkt_last !== 1'b0) $display("FAIL reset_last: got %b want 0", pkt_last); else n_pass++;
    n_total++; if (wr_drop !== 1'b0) $display("FAIL reset_drop: got %b want 0", wr_drop); else n_pass++;
  endtask

  task automatic test_packet();
    logic [7:0] pkt [5];
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h3C};
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) wr(i == 0, pkt[i]);
    n_total++; if (empty !== 1'b0) $display("FAIL pkt_empty: got %b want 0", empty); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      rd();
      n_total++;
      if (data_out !== pkt[i]) $display("FAIL pkt_data[%0d]: got %h want %h", i, data_out, pkt[i]);
      else n_pass++;
      n_total++;
      if (pkt_last !== (i == 4)) $display("FAIL pkt_last[%0d]: got %b want %b", i, pkt_last, (i == 4));
      else n_pass++;
    end
    idle();
    n_total++; if (pkt_last !== 1'b0) $display("FAIL pkt_last_idle: got %b want 0", pkt_last); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL pkt_empty_end: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_full();
    logic [7:0] exp;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      n_total++; if (full !== 1'b0) $display("FAIL full_early[%0d]: got %b want 0", i, full); else n_pass++;
      wr(1'b0, 8'hA0 + 8'(i));
    end
    n_total++; if (full !== 1'b1) $display("FAIL full_set: got %b want 1", full); else n_pass++;
    wr(1'b0, 8'hEE);
    n_total++; if (wr_drop !== 1'b1) $display("FAIL full_drop: got %b want 1", wr_drop); else n_pass++;
    idle();
    n_total++; if (wr_drop !== 1'b0) $display("FAIL full_drop_pulse: got %b want 0", wr_drop); else n_pass++;
    rd();
    n_total++; if (data_out !== 8'hA0) $display("FAIL full_first: got %h want a0", data_out); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL full_clear: got %b want 0", full); else n_pass++;
    for (int i = 1; i < 16; i++) begin
      rd();
      exp = 8'hA0 + 8'(i);
      n_total++; if (data_out !== exp) $display("FAIL full_drain[%0d]: got %h want %h", i, data_out, exp); else n_pass++;
    end
    n_total++; if (empty !== 1'b1) $display("FAIL full_empty_end: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) wr(1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      rd(); exp = 8'h30 + 8'(i);
      n_total++; if (data_out !== exp) $display("FAIL wrap_a[%0d]: got %h want %h", i, data_out, exp); else n_pass++;
    end
    for (int i = 0; i < 12; i++) wr(1'b0, 8'h60 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      rd(); exp = 8'h60 + 8'(i);
      n_total++; if (data_out !== exp) $display("FAIL wrap_b[%0d]: got %h want %h", i, data_out, exp); else n_pass++;
    end
    n_total++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_simul();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    wr(1'b0, 8'h5A);
    rd();
    cyc(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
    n_total++; if (data_out !== 8'h5A) $display("FAIL simul_hold: got %h want 5a", data_out); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL simul_stored: got %b want 0", empty); else n_pass++;
    rd();
    n_total++; if (data_out !== 8'h77) $display("FAIL simul_rd: got %h want 77", data_out); else n_pass++;
    for (int i = 0; i < 16; i++) wr(1'b0, 8'hC0 + 8'(i));
    cyc(1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0);
    n_total++; if (data_out !== 8'hC0) $display("FAIL simul_full_rd: got %h want c0", data_out); else n_pass++;
    n_total++; if (wr_drop !== 1'b1) $display("FAIL simul_full_drop: got %b want 1", wr_drop); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL simul_full_flag: got %b want 0", full); else n_pass++;
  endtask

  task automatic test_flush();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    wr(1'b1, 8'h14);
    wr(1'b0, 8'h01); wr(1'b0, 8'h02); wr(1'b0, 8'h03);
    rd(); rd(); rd();
    n_total++; if (data_out !== 8'h02) $display("FAIL flush_pre: got %h want 02", data_out); else n_pass++;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_total++; if (empty !== 1'b1) $display("FAIL flush_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (data_out !== 8'h00) $display("FAIL flush_dout: got %h want 00", data_out); else n_pass++;
    wr(1'b1, 8'h04); wr(1'b0, 8'hAA); wr(1'b0, 8'h55);
    rd();
    n_total++; if (pkt_last !== 1'b0) $display("FAIL flush_hdr_last: got %b want 0", pkt_last); else n_pass++;
    rd();
    n_total++; if (pkt_last !== 1'b0) $display("FAIL flush_pay_last: got %b want 0", pkt_last); else n_pass++;
    rd();
    n_total++; if (data_out !== 8'h55) $display("FAIL flush_par_data: got %h want 55", data_out); else n_pass++;
    n_total++; if (pkt_last !== 1'b1) $display("FAIL flush_par_last: got %b want 1", pkt_last); else n_pass++;
    // Orphan byte after the packet has ended: data passes, never flagged last.
    wr(1'b0, 8'h66); rd();
    n_total++; if (pkt_last !== 1'b0) $display("FAIL orphan_last: got %b want 0", pkt_last); else n_pass++;
  endtask

  task automatic test_random();
    logic we, lfd, re, sr;
    logic [7:0] din;
    int hdr_len;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      we  = ($urandom_range(0, 99) < 60);
      re  = ($urandom_range(0, 99) < 50);
      lfd = ($urandom_range(0, 3) == 0);
      sr  = ($urandom_range(0, 99) == 0);
      hdr_len = $urandom_range(0, 7);
      if (lfd) din = {6'(hdr_len == 7 ? 63 : hdr_len), 2'($urandom_range(0, 2))};
      else     din = 8'($urandom);
      cyc(we, lfd, din, re, sr, 1'b0);
      n_total++;
      if (data_out !== m_dout || pkt_last !== m_last || wr_drop !== m_drop ||
          full !== (q.size() == 16) || empty !== (q.size() == 0)) begin
        $display("FAIL rand[%0d]: got d=%h l=%b dr=%b f=%b e=%b want d=%h l=%b dr=%b f=%b e=%b",
                 i, data_out, pkt_last, wr_drop, full, empty,
                 m_dout, m_last, m_drop, (q.size() == 16), (q.size() == 0));
      end else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    data_in = 8'h00; read_enb = 1'b0;
    m_count = 0; m_dout = 8'h00; m_last = 1'b0; m_drop = 1'b0;
    test_reset();
    test_packet();
    test_full();
    test_wrap();
    test_simul();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_router_fifo
